// File: rtl/idle_ctrl.sv
// CPU idle entry/exit sequencer around the core PLL: drains the bus, drives the
// PLL bypass level, waits for relock on wake and keeps idle-cycle statistics.
module idle_ctrl #(
  parameter int ENTRY_DELAY  = 4,
  parameter int MIN_IDLE     = 8,
  parameter int LOCK_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk_ref,
  input  logic             rst,
  input  logic             wfi_req,
  input  logic             irq_pending,
  input  logic             bus_busy,
  input  logic             pll_lock,
  input  logic             clr_stats,
  output logic             wfi,
  output logic             core_hold,
  output logic             wake_ack,
  output logic             lock_timeout_err,
  output logic [CNT_W-1:0] idle_cycles
);

  localparam int DCW = $clog2(ENTRY_DELAY + 1);
  localparam int ICW = $clog2(MIN_IDLE + 1);
  localparam int TCW = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(ENTRY_DELAY - 1);
  localparam logic [ICW-1:0] DWELL_LAST = ICW'(MIN_IDLE - 1);
  localparam logic [TCW-1:0] TMO_LAST   = TCW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    IDLE   = 2'd2,
    RELOCK = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [DCW-1:0]   drain_cnt_reg, drain_cnt_next;
  logic [ICW-1:0]   dwell_cnt_reg, dwell_cnt_next;
  logic [TCW-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic             wake_ack_reg, wake_ack_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic             lock_meta_reg, lock_s_reg;
  logic             wake;
  logic             timeout_hit;

  // pll_lock comes from the PLL's own domain; two flops before use.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      lock_meta_reg <= 1'b0;
      lock_s_reg    <= 1'b0;
    end else begin
      lock_meta_reg <= pll_lock;
      lock_s_reg    <= lock_meta_reg;
    end
  end

  assign wake = irq_pending | ~wfi_req;

  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_reg     <= RUN;
      drain_cnt_reg <= '0;
      dwell_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
      wake_ack_reg  <= 1'b0;
      err_reg       <= 1'b0;
      idle_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      dwell_cnt_reg <= dwell_cnt_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      wake_ack_reg  <= wake_ack_next;
      err_reg       <= err_next;
      idle_cnt_reg  <= idle_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    dwell_cnt_next = dwell_cnt_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    timeout_hit    = 1'b0;

    case (state_reg)
      RUN: begin
        if (wfi_req && !irq_pending) begin
          state_next     = DRAIN;
          drain_cnt_next = '0;
        end
      end
      DRAIN: begin
        if (wake) begin
          state_next = RUN;
        end else if (bus_busy) begin
          drain_cnt_next = '0;
        end else begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
          if (drain_cnt_reg == DRAIN_LAST) begin
            state_next     = IDLE;
            dwell_cnt_next = '0;
          end
        end
      end
      IDLE: begin
        // Wake is masked until the minimum dwell has run out.
        if (dwell_cnt_reg != DWELL_LAST) begin
          dwell_cnt_next = dwell_cnt_reg + 1'b1;
        end else if (wake) begin
          state_next   = RELOCK;
          tmo_cnt_next = '0;
        end
      end
      RELOCK: begin
        if (lock_s_reg) begin
          state_next = RUN;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next  = RUN;
          timeout_hit = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    wake_ack_next = (state_next == RUN) && (state_reg != RUN);
    err_next      = err_reg | timeout_hit;

    idle_cnt_next = idle_cnt_reg;
    if (clr_stats) begin
      idle_cnt_next = '0;
    end else if ((state_reg == IDLE) && (idle_cnt_reg != {CNT_W{1'b1}})) begin
      idle_cnt_next = idle_cnt_reg + 1'b1;
    end
  end

  assign wfi              = (state_reg == IDLE);
  assign core_hold        = (state_reg != RUN);
  assign wake_ack         = wake_ack_reg;
  assign lock_timeout_err = err_reg;
  assign idle_cycles      = idle_cnt_reg;

endmodule

// File: tb/tb_idle_ctrl.sv
// Directed bench for idle_ctrl: table-driven cycle vectors plus hand-written
// sequences for relock timeout, reset mid-idle and counter saturation.
module tb_idle_ctrl;

  logic clk_ref = 1'b0;
  always #5 clk_ref = ~clk_ref;

  logic        rst, wfi_req, irq_pending, bus_busy, pll_lock, clr_stats;
  logic        wfi, core_hold, wake_ack, lock_timeout_err;
  logic [31:0] idle_cycles;
  logic        wfi4, core_hold4, wake_ack4, lock_timeout_err4;
  logic [3:0]  idle_cycles4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  idle_ctrl dut (
    .clk_ref(clk_ref), .rst(rst), .wfi_req(wfi_req), .irq_pending(irq_pending),
    .bus_busy(bus_busy), .pll_lock(pll_lock), .clr_stats(clr_stats),
    .wfi(wfi), .core_hold(core_hold), .wake_ack(wake_ack),
    .lock_timeout_err(lock_timeout_err), .idle_cycles(idle_cycles)
  );

  idle_ctrl #(.CNT_W(4)) dut4 (
    .clk_ref(clk_ref), .rst(rst), .wfi_req(wfi_req), .irq_pending(irq_pending),
    .bus_busy(bus_busy), .pll_lock(pll_lock), .clr_stats(clr_stats),
    .wfi(wfi4), .core_hold(core_hold4), .wake_ack(wake_ack4),
    .lock_timeout_err(lock_timeout_err4), .idle_cycles(idle_cycles4)
  );

  typedef struct {
    logic wr, irq, busy, lock, clr;
    logic ewfi, ehold, eack, eerr;
    int   eidle;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic wr, input logic irq, input logic busy,
                              input logic lock, input logic clr, input logic ewfi,
                              input logic ehold, input logic eack, input logic eerr,
                              input int eidle);
    vec_t v;
    v.wr = wr; v.irq = irq; v.busy = busy; v.lock = lock; v.clr = clr;
    v.ewfi = ewfi; v.ehold = ehold; v.eack = eack; v.eerr = eerr; v.eidle = eidle;
    tbl.push_back(v);
  endfunction

  task automatic step();
    @(posedge clk_ref);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic ewfi, input logic ehold,
                         input logic eack, input logic eerr, input int eidle);
    int eidle4;
    eidle4 = (eidle > 15) ? 15 : eidle;
    chk({nm, ".wfi"}, {31'd0, wfi}, {31'd0, ewfi});
    chk({nm, ".core_hold"}, {31'd0, core_hold}, {31'd0, ehold});
    chk({nm, ".wake_ack"}, {31'd0, wake_ack}, {31'd0, eack});
    chk({nm, ".lock_timeout_err"}, {31'd0, lock_timeout_err}, {31'd0, eerr});
    chk({nm, ".idle_cycles"}, idle_cycles, eidle);
    chk({nm, ".wfi4"}, {31'd0, wfi4}, {31'd0, ewfi});
    chk({nm, ".core_hold4"}, {31'd0, core_hold4}, {31'd0, ehold});
    chk({nm, ".wake_ack4"}, {31'd0, wake_ack4}, {31'd0, eack});
    chk({nm, ".idle_cycles4"}, {28'd0, idle_cycles4}, eidle4);
  endtask

  task automatic set_in(input logic wr, input logic irq, input logic busy,
                        input logic lock, input logic clr);
    wfi_req = wr; irq_pending = irq; bus_busy = busy; pll_lock = lock; clr_stats = clr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_until(input int n);
    for (int k = 0; k < 200 && cyc < n; k++) step();
  endtask

  task automatic run_table(input string nm);
    int errs0;
    foreach (tbl[i]) begin
      set_in(tbl[i].wr, tbl[i].irq, tbl[i].busy, tbl[i].lock, tbl[i].clr);
      errs0 = bad;
      chk_out($sformatf("%s[%0d]", nm, i), tbl[i].ewfi, tbl[i].ehold,
              tbl[i].eack, tbl[i].eerr, tbl[i].eidle);
      $display("%s row %0d: wfi=%0b hold=%0b ack=%0b err=%0b idle=%0d %s", nm, i,
               wfi, core_hold, wake_ack, lock_timeout_err, idle_cycles,
               (bad == errs0) ? "ok" : "bad");
      step();
    end
    tbl.delete();
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0);

    // Idle entry, minimum dwell with early irq, relock 10 cycles after wfi falls.
    do_reset();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 5; i <= 12; i++) add(1, 1, 0, 0, 0, 1, 1, 0, 0, i - 5);
    for (int i = 13; i <= 25; i++) add(1, 1, 0, logic'(i >= 23), 0, 0, 1, 0, 0, 8);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0, 8);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 8);
    run_table("entry");

    // Bus busy during drain reloads the entry delay.
    do_reset();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    for (int i = 4; i <= 7; i++) add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 1, 0, 0, 1);
    run_table("reload");

    // Interrupt during drain aborts entry without asserting wfi.
    do_reset();
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_table("abort");

    // Lock timeout, then a second idle round with the error still sticky.
    do_reset();
    chk_out("reset", 0, 0, 0, 0, 0);
    set_in(1, 0, 0, 0, 0);
    run_until(5);
    chk_out("tmo.idle", 1, 1, 0, 0, 0);
    irq_pending = 1'b1;
    run_until(13);
    for (int i = 13; i <= 76; i++) begin
      chk("tmo.relock_hold", {31'd0, core_hold}, 32'd1);
      chk("tmo.relock_err", {31'd0, lock_timeout_err}, 32'd0);
      step();
    end
    chk_out("tmo.exit", 0, 0, 1, 1, 8);
    $display("timeout exit at cyc=%0d err=%0b", cyc, lock_timeout_err);
    irq_pending = 1'b0;
    run_until(82);
    chk_out("tmo.idle2", 1, 1, 0, 1, 8);
    irq_pending = 1'b1;
    run_until(90);
    chk_out("tmo.relock2", 0, 1, 0, 1, 16);
    pll_lock = 1'b1;
    run_until(92);
    chk_out("tmo.relock2_wait", 0, 1, 0, 1, 16);
    step();
    chk_out("tmo.lock_exit2", 0, 0, 1, 1, 16);
    set_in(0, 0, 0, 1, 0);
    run_until(100);
    chk_out("tmo.sticky", 0, 0, 0, 1, 16);
    do_reset();
    chk_out("tmo.cleared", 0, 0, 0, 0, 0);
    $display("sticky error check done at cyc=%0d", cyc);

    // Lock arriving on the timeout cycle wins: no error.
    set_in(1, 0, 0, 0, 0);
    run_until(5);
    irq_pending = 1'b1;
    run_until(74);
    pll_lock = 1'b1;
    run_until(76);
    chk_out("edge.last_relock", 0, 1, 0, 0, 8);
    step();
    chk_out("edge.lock_exit", 0, 0, 1, 0, 8);
    $display("lock-on-timeout check done at cyc=%0d", cyc);

    // Reset mid-idle, then saturation and clear of the idle counter.
    do_reset();
    set_in(1, 0, 0, 0, 0);
    run_until(7);
    chk_out("rst.idle", 1, 1, 0, 0, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_out("rst.after", 0, 0, 0, 0, 0);
    run_until(13);
    chk_out("sat.idle", 1, 1, 0, 0, 0);
    run_until(33);
    chk_out("sat.full", 1, 1, 0, 0, 20);
    clr_stats = 1'b1;
    step();
    chk_out("sat.clr", 1, 1, 0, 0, 0);
    clr_stats = 1'b0;
    step();
    chk_out("sat.recount", 1, 1, 0, 0, 1);
    $display("counter checks done at cyc=%0d", cyc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
